// File: rtl/airi5c_float_result_sequencer.sv
// In-order completion sequencer for the FPU arithmetic units.
//
// Each issued op gets a tag. The tag is the slot at the tail pointer. The
// arithmetic units complete out of order by tag through their own completion
// ports. Results are then presented to post-processing strictly in issue
// order through a valid/ready handshake. Each slot also stores the rounding
// mode and the unit index that were latched at issue.
//
// Ports
//   clk, n_reset     clock, asynchronous active-low reset
//   kill             synchronous flush of every entry (also clears proto_err)
//   issue_*          dispatch handshake; issue_tag is the tag being allocated
//   fu_*             per-unit completion lanes, unit i packed at [i*W +: W]
//   out_*            head-of-queue result, zero while out_valid is low
//   count            number of allocated entries (0..DEPTH)
//   proto_err        sticky flag for completions that hit a FREE or DONE slot,
//                    or for two units completing the same tag in one cycle
module airi5c_float_result_sequencer #(
   parameter  int N_UNITS = 4,
   parameter  int TAG_W   = 2,
   parameter  int MAN_W   = 24,
   parameter  int EXP_W   = 10,
   localparam int UNIT_W  = (N_UNITS > 1) ? $clog2(N_UNITS) : 1
) (
   input  logic                     clk,
   input  logic                     n_reset,
   input  logic                     kill,
   input  logic                     issue_valid,
   output logic                     issue_ready,
   input  logic [UNIT_W-1:0]        issue_unit,
   input  logic [2:0]               issue_rm,
   output logic [TAG_W-1:0]         issue_tag,
   input  logic [N_UNITS-1:0]       fu_valid,
   input  logic [N_UNITS*TAG_W-1:0] fu_tag,
   input  logic [N_UNITS*MAN_W-1:0] fu_man,
   input  logic [N_UNITS*EXP_W-1:0] fu_exp,
   input  logic [N_UNITS-1:0]       fu_sgn,
   input  logic [N_UNITS-1:0]       fu_round,
   input  logic [N_UNITS-1:0]       fu_sticky,
   input  logic [N_UNITS-1:0]       fu_iv,
   input  logic [N_UNITS-1:0]       fu_dz,
   input  logic [N_UNITS-1:0]       fu_final,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [MAN_W-1:0]         out_man,
   output logic [EXP_W-1:0]         out_exp,
   output logic                     out_sgn,
   output logic                     out_round,
   output logic                     out_sticky,
   output logic                     out_iv,
   output logic                     out_dz,
   output logic                     out_final,
   output logic [2:0]               out_rm,
   output logic [UNIT_W-1:0]        out_unit,
   output logic [TAG_W-1:0]         out_tag,
   output logic [TAG_W:0]           count,
   output logic                     proto_err
);

   localparam int DEPTH = 1 << TAG_W;

   typedef enum logic [1:0] {
      SLOT_FREE,
      SLOT_PENDING,
      SLOT_DONE
   } slot_state_t;

   slot_state_t        state_q [DEPTH];
   slot_state_t        state_d [DEPTH];
   logic [TAG_W-1:0]   head_q, head_d;
   logic [TAG_W-1:0]   tail_q, tail_d;
   logic [TAG_W:0]     count_q, count_d;
   logic               proto_err_q, proto_err_d;

   logic [2:0]         rm_q   [DEPTH];
   logic [UNIT_W-1:0]  unit_q [DEPTH];
   logic [MAN_W-1:0]   man_q  [DEPTH];
   logic [EXP_W-1:0]   exp_q  [DEPTH];
   logic [5:0]         flg_q  [DEPTH];   // {sgn, round, sticky, iv, dz, final}

   logic [5:0]         fu_flg  [N_UNITS];
   logic [DEPTH-1:0]   hit;
   logic [DEPTH-1:0]   cap_en;
   logic [MAN_W-1:0]   cap_man [DEPTH];
   logic [EXP_W-1:0]   cap_exp [DEPTH];
   logic [5:0]         cap_flg [DEPTH];
   logic               comp_err;

   logic               issue_fire;
   logic               retire;

   // The queue is full exactly when the MSB of count is set, because count
   // never exceeds DEPTH. Retiring in the same cycle does not free a slot
   // for issue until the next cycle.
   assign issue_ready = ~count_q[TAG_W];
   assign issue_fire  = issue_valid & issue_ready;
   assign retire      = out_valid & out_ready;
   assign issue_tag   = tail_q;
   assign count       = count_q;
   assign proto_err   = proto_err_q;

   always_comb begin
      for (int unsigned i = 0; i < N_UNITS; i++) begin
         fu_flg[i] = {fu_sgn[i], fu_round[i], fu_sticky[i], fu_iv[i], fu_dz[i], fu_final[i]};
      end
   end

   // Each slot selects the lowest-index unit that targets it. Any further
   // unit hitting the same slot, or any hit on a slot that is not PENDING,
   // is a protocol error and the completion is dropped.
   always_comb begin
      hit      = '0;
      cap_en   = '0;
      comp_err = 1'b0;
      for (int unsigned s = 0; s < DEPTH; s++) begin
         cap_man[s] = '0;
         cap_exp[s] = '0;
         cap_flg[s] = '0;
         for (int unsigned i = 0; i < N_UNITS; i++) begin
            if (fu_valid[i] && (fu_tag[i*TAG_W +: TAG_W] == TAG_W'(s))) begin
               if (hit[s]) begin
                  comp_err = 1'b1;
               end else begin
                  hit[s]     = 1'b1;
                  cap_man[s] = fu_man[i*MAN_W +: MAN_W];
                  cap_exp[s] = fu_exp[i*EXP_W +: EXP_W];
                  cap_flg[s] = fu_flg[i];
               end
            end
         end
         if (hit[s]) begin
            if (state_q[s] == SLOT_PENDING) cap_en[s] = 1'b1;
            else                            comp_err  = 1'b1;
         end
      end
   end

   // Slot states and pointers. The head slot is DONE and the tail slot is
   // FREE, and only PENDING slots capture, so the retire, completion and
   // issue updates never target the same slot in one cycle.
   always_comb begin
      for (int unsigned s = 0; s < DEPTH; s++) state_d[s] = state_q[s];
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      proto_err_d = proto_err_q;
      if (kill) begin
         for (int unsigned s = 0; s < DEPTH; s++) state_d[s] = SLOT_FREE;
         head_d      = '0;
         tail_d      = '0;
         count_d     = '0;
         proto_err_d = 1'b0;
      end else begin
         for (int unsigned s = 0; s < DEPTH; s++) begin
            if (cap_en[s]) state_d[s] = SLOT_DONE;
         end
         if (retire) begin
            state_d[head_q] = SLOT_FREE;
            head_d          = head_q + TAG_W'(1);
         end
         if (issue_fire) begin
            state_d[tail_q] = SLOT_PENDING;
            tail_d          = tail_q + TAG_W'(1);
         end
         unique case ({issue_fire, retire})
            2'b10:   count_d = count_q + (TAG_W+1)'(1);
            2'b01:   count_d = count_q - (TAG_W+1)'(1);
            default: count_d = count_q;
         endcase
         proto_err_d = proto_err_q | comp_err;
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         for (int unsigned s = 0; s < DEPTH; s++) state_q[s] <= SLOT_FREE;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         proto_err_q <= 1'b0;
      end else begin
         for (int unsigned s = 0; s < DEPTH; s++) state_q[s] <= state_d[s];
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         proto_err_q <= proto_err_d;
      end
   end

   // Payload storage. It is not cleared on kill, because the outputs are
   // gated by the slot state.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         for (int unsigned s = 0; s < DEPTH; s++) begin
            rm_q[s]   <= '0;
            unit_q[s] <= '0;
            man_q[s]  <= '0;
            exp_q[s]  <= '0;
            flg_q[s]  <= '0;
         end
      end else if (!kill) begin
         if (issue_fire) begin
            rm_q[tail_q]   <= issue_rm;
            unit_q[tail_q] <= issue_unit;
         end
         for (int unsigned s = 0; s < DEPTH; s++) begin
            if (cap_en[s]) begin
               man_q[s] <= cap_man[s];
               exp_q[s] <= cap_exp[s];
               flg_q[s] <= cap_flg[s];
            end
         end
      end
   end

   always_comb begin
      out_valid  = (state_q[head_q] == SLOT_DONE);
      out_man    = '0;
      out_exp    = '0;
      out_sgn    = 1'b0;
      out_round  = 1'b0;
      out_sticky = 1'b0;
      out_iv     = 1'b0;
      out_dz     = 1'b0;
      out_final  = 1'b0;
      out_rm     = '0;
      out_unit   = '0;
      out_tag    = '0;
      if (out_valid) begin
         out_man  = man_q[head_q];
         out_exp  = exp_q[head_q];
         {out_sgn, out_round, out_sticky, out_iv, out_dz, out_final} = flg_q[head_q];
         out_rm   = rm_q[head_q];
         out_unit = unit_q[head_q];
         out_tag  = head_q;
      end
   end

endmodule

// File: tb/tb_airi5c_float_result_sequencer.sv
module tb_airi5c_float_result_sequencer;

   localparam int N_UNITS = 4;
   localparam int TAG_W   = 2;
   localparam int MAN_W   = 24;
   localparam int EXP_W   = 10;
   localparam int UNIT_W  = 2;
   localparam int DEPTH   = 4;

   logic                     clk = 1'b0;
   logic                     n_reset = 1'b0;
   logic                     kill = 1'b0;
   logic                     issue_valid = 1'b0;
   logic                     issue_ready;
   logic [UNIT_W-1:0]        issue_unit = '0;
   logic [2:0]               issue_rm = '0;
   logic [TAG_W-1:0]         issue_tag;
   logic [N_UNITS-1:0]       fu_valid = '0;
   logic [N_UNITS*TAG_W-1:0] fu_tag = '0;
   logic [N_UNITS*MAN_W-1:0] fu_man = '0;
   logic [N_UNITS*EXP_W-1:0] fu_exp = '0;
   logic [N_UNITS-1:0]       fu_sgn = '0, fu_round = '0, fu_sticky = '0;
   logic [N_UNITS-1:0]       fu_iv = '0, fu_dz = '0, fu_final = '0;
   logic                     out_valid;
   logic                     out_ready = 1'b0;
   logic [MAN_W-1:0]         out_man;
   logic [EXP_W-1:0]         out_exp;
   logic                     out_sgn, out_round, out_sticky, out_iv, out_dz, out_final;
   logic [2:0]               out_rm;
   logic [UNIT_W-1:0]        out_unit;
   logic [TAG_W-1:0]         out_tag;
   logic [TAG_W:0]           count;
   logic                     proto_err;

   airi5c_float_result_sequencer #(
      .N_UNITS(N_UNITS), .TAG_W(TAG_W), .MAN_W(MAN_W), .EXP_W(EXP_W)
   ) dut (
      .clk(clk), .n_reset(n_reset), .kill(kill),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_unit(issue_unit),
      .issue_rm(issue_rm), .issue_tag(issue_tag),
      .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_man(fu_man), .fu_exp(fu_exp),
      .fu_sgn(fu_sgn), .fu_round(fu_round), .fu_sticky(fu_sticky),
      .fu_iv(fu_iv), .fu_dz(fu_dz), .fu_final(fu_final),
      .out_valid(out_valid), .out_ready(out_ready), .out_man(out_man), .out_exp(out_exp),
      .out_sgn(out_sgn), .out_round(out_round), .out_sticky(out_sticky),
      .out_iv(out_iv), .out_dz(out_dz), .out_final(out_final),
      .out_rm(out_rm), .out_unit(out_unit), .out_tag(out_tag),
      .count(count), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [TAG_W-1:0]  tag;
      logic [2:0]        rm;
      logic [UNIT_W-1:0] unit;
   } sb_t;

   sb_t              sb[$];
   int               errors = 0;
   int               checks = 0;
   int               m_tail = 0;
   int               m_count = 0;
   logic [MAN_W-1:0] m_man [DEPTH];
   logic [EXP_W-1:0] m_exp [DEPTH];
   logic [5:0]       m_flg [DEPTH];

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_kill();
      kill = 1'b1;
      tick();
      kill = 1'b0;
      m_tail  = 0;
      m_count = 0;
      sb.delete();
   endtask

   task automatic do_issue(input logic [2:0] rm, input logic [UNIT_W-1:0] unit);
      sb_t e;
      e.tag  = TAG_W'(m_tail);
      e.rm   = rm;
      e.unit = unit;
      sb.push_back(e);
      issue_valid = 1'b1;
      issue_rm    = rm;
      issue_unit  = unit;
      tick();
      issue_valid = 1'b0;
      m_tail  = (m_tail + 1) % DEPTH;
      m_count = m_count + 1;
   endtask

   task automatic set_fu(input int u, input logic [TAG_W-1:0] tag, input logic [MAN_W-1:0] man,
                         input logic [EXP_W-1:0] ex, input logic [5:0] fl, input bit upd);
      fu_valid[u]               = 1'b1;
      fu_tag[u*TAG_W +: TAG_W]  = tag;
      fu_man[u*MAN_W +: MAN_W]  = man;
      fu_exp[u*EXP_W +: EXP_W]  = ex;
      fu_sgn[u]    = fl[5];
      fu_round[u]  = fl[4];
      fu_sticky[u] = fl[3];
      fu_iv[u]     = fl[2];
      fu_dz[u]     = fl[1];
      fu_final[u]  = fl[0];
      if (upd) begin
         m_man[tag] = man;
         m_exp[tag] = ex;
         m_flg[tag] = fl;
      end
   endtask

   task automatic fu_tick();
      tick();
      fu_valid = '0; fu_tag = '0; fu_man = '0; fu_exp = '0;
      fu_sgn = '0; fu_round = '0; fu_sticky = '0; fu_iv = '0; fu_dz = '0; fu_final = '0;
   endtask

   task automatic retire_one();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      m_count = m_count - 1;
   endtask

   // Scoreboard: wait (bounded) for a head result, pop the oldest expected
   // entry and compare it with the head result.
   task automatic sb_check_head(input string name);
      int  n = 0;
      sb_t e;
      while (out_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s head_wait: out_valid=%b required 1 within 20 cycles", name, out_valid);
         return;
      end
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s sb_empty: out_valid=1 out_tag=%0d required no result", name, out_tag);
         return;
      end
      e = sb.pop_front();
      checks++;
      if ({out_tag, out_rm, out_unit} !== {e.tag, e.rm, e.unit}) begin
         errors++;
         $display("FAIL %s tag_rm_unit: got tag=%0d rm=%0d unit=%0d required tag=%0d rm=%0d unit=%0d",
                  name, out_tag, out_rm, out_unit, e.tag, e.rm, e.unit);
      end
      checks++;
      if ({out_man, out_exp} !== {m_man[e.tag], m_exp[e.tag]}) begin
         errors++;
         $display("FAIL %s man_exp: got %h/%h required %h/%h", name, out_man, out_exp,
                  m_man[e.tag], m_exp[e.tag]);
      end
      checks++;
      if ({out_sgn, out_round, out_sticky, out_iv, out_dz, out_final} !== m_flg[e.tag]) begin
         errors++;
         $display("FAIL %s flags: got %b required %b", name,
                  {out_sgn, out_round, out_sticky, out_iv, out_dz, out_final}, m_flg[e.tag]);
      end
   endtask

   task automatic test_reset();
      n_reset = 1'b0;
      #12;
      checks++;
      if ({issue_ready, issue_tag, out_valid, count, proto_err} !== {1'b1, 2'd0, 1'b0, 3'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_ctrl: got rdy=%b tag=%0d ov=%b cnt=%0d perr=%b required 1 0 0 0 0",
                  issue_ready, issue_tag, out_valid, count, proto_err);
      end
      checks++;
      if ({out_man, out_exp, out_sgn, out_round, out_sticky, out_iv, out_dz, out_final,
           out_rm, out_unit, out_tag} !== '0) begin
         errors++;
         $display("FAIL reset_out: got man=%h exp=%h rm=%0d unit=%0d tag=%0d required all zero",
                  out_man, out_exp, out_rm, out_unit, out_tag);
      end
      @(negedge clk);
      n_reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_in_order();
      do_issue(3'd1, 2'd0);
      do_issue(3'd3, 2'd2);
      checks++;
      if (count !== 3'd2) begin errors++; $display("FAIL inorder_cnt2: got %0d required 2", count); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL inorder_pending: out_valid=%b required 0", out_valid); end
      set_fu(0, 2'd0, 24'h800000, 10'h07F, 6'b000000, 1'b1);
      fu_tick();
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL inorder_latency: out_valid=%b required 1", out_valid); end
      set_fu(2, 2'd1, 24'h123456, 10'h100, 6'b100001, 1'b1);
      fu_tick();
      sb_check_head("inorder0");
      retire_one();
      checks++;
      if (count !== 3'd1) begin errors++; $display("FAIL inorder_cnt1: got %0d required 1", count); end
      sb_check_head("inorder1");
      retire_one();
      checks++;
      if ({count, out_valid} !== {3'd0, 1'b0}) begin
         errors++;
         $display("FAIL inorder_empty: got cnt=%0d ov=%b required 0 0", count, out_valid);
      end
   endtask

   task automatic test_out_of_order();
      do_kill();
      do_issue(3'd2, 2'd0);
      do_issue(3'd4, 2'd1);
      set_fu(1, 2'd1, 24'h7FFFFF, 10'h200, 6'b010010, 1'b1);
      fu_tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL ooo_blocked: out_valid=%b required 0", out_valid); end
      set_fu(0, 2'd0, 24'h000001, 10'h001, 6'b001000, 1'b1);
      fu_tick();
      sb_check_head("ooo0");
      out_ready = 1'b1;
      tick();
      m_count--;
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL ooo_next: out_valid=%b required 1", out_valid); end
      sb_check_head("ooo1");
      tick();
      out_ready = 1'b0;
      m_count--;
      checks++;
      if ({count, out_valid} !== {3'd0, 1'b0}) begin
         errors++;
         $display("FAIL ooo_empty: got cnt=%0d ov=%b required 0 0", count, out_valid);
      end
   endtask

   task automatic test_full_wrap();
      do_kill();
      for (int i = 0; i < DEPTH; i++) do_issue(3'(i), UNIT_W'(i));
      checks++;
      if ({count, issue_ready, issue_tag} !== {3'd4, 1'b0, 2'd0}) begin
         errors++;
         $display("FAIL full_state: got cnt=%0d rdy=%b tag=%0d required 4 0 0", count, issue_ready, issue_tag);
      end
      issue_valid = 1'b1;
      issue_rm    = 3'd7;
      tick();
      issue_valid = 1'b0;
      checks++;
      if (count !== 3'd4) begin errors++; $display("FAIL full_reject: got cnt=%0d required 4", count); end
      set_fu(3, 2'd0, 24'hABCDEF, 10'h3FF, 6'b010101, 1'b1);
      fu_tick();
      sb_check_head("full0");
      // Retire and attempt an issue in the same cycle: no bypass.
      out_ready   = 1'b1;
      issue_valid = 1'b1;
      issue_rm    = 3'd5;
      tick();
      out_ready   = 1'b0;
      issue_valid = 1'b0;
      m_count--;
      checks++;
      if ({count, issue_ready, issue_tag} !== {3'd3, 1'b1, 2'd0}) begin
         errors++;
         $display("FAIL wrap_state: got cnt=%0d rdy=%b tag=%0d required 3 1 0", count, issue_ready, issue_tag);
      end
      do_issue(3'd5, 2'd1);
      checks++;
      if ({count, issue_tag} !== {3'd4, 2'd1}) begin
         errors++;
         $display("FAIL wrap_issue: got cnt=%0d tag=%0d required 4 1", count, issue_tag);
      end
   endtask

   task automatic test_backpressure();
      set_fu(2, 2'd1, 24'h400001, 10'h081, 6'b001100, 1'b1);
      fu_tick();
      for (int c = 0; c < 5; c++) begin
         checks++;
         if ({out_valid, out_tag, out_man, out_exp, count} !==
             {1'b1, sb[0].tag, m_man[sb[0].tag], m_exp[sb[0].tag], 3'd4}) begin
            errors++;
            $display("FAIL bp_stable%0d: got ov=%b tag=%0d man=%h exp=%h cnt=%0d required 1 %0d %h %h 4",
                     c, out_valid, out_tag, out_man, out_exp, count, sb[0].tag,
                     m_man[sb[0].tag], m_exp[sb[0].tag]);
         end
         tick();
      end
      sb_check_head("bp");
      retire_one();
      checks++;
      if ({count, out_valid} !== {3'd3, 1'b0}) begin
         errors++;
         $display("FAIL bp_single: got cnt=%0d ov=%b required 3 0", count, out_valid);
      end
   endtask

   task automatic test_simultaneous();
      do_kill();
      for (int i = 0; i < DEPTH; i++) do_issue(3'(7 - i), UNIT_W'(3 - i));
      for (int u = 0; u < N_UNITS; u++)
         set_fu(u, TAG_W'(u), 24'(24'h100000 + u * 3), 10'(10'h040 + u), 6'(1 << u), 1'b1);
      fu_tick();
      checks++;
      if (proto_err !== 1'b0) begin errors++; $display("FAIL simul_perr: got %b required 0", proto_err); end
      out_ready = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         sb_check_head("simul");
         tick();
         m_count--;
      end
      out_ready = 1'b0;
      checks++;
      if ({count, out_valid, proto_err} !== {3'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL simul_end: got cnt=%0d ov=%b perr=%b required 0 0 0", count, out_valid, proto_err);
      end
   endtask

   task automatic test_errors_kill();
      set_fu(1, 2'd2, 24'hDEAD00, 10'h155, 6'b111111, 1'b0);
      fu_tick();
      checks++;
      if ({proto_err, out_valid, count} !== {1'b1, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL err_free: got perr=%b ov=%b cnt=%0d required 1 0 0", proto_err, out_valid, count);
      end
      for (int i = 0; i < 3; i++) do_issue(3'd6, 2'd3);
      checks++;
      if ({proto_err, count} !== {1'b1, 3'd3}) begin
         errors++;
         $display("FAIL err_sticky: got perr=%b cnt=%0d required 1 3", proto_err, count);
      end
      do_kill();
      checks++;
      if ({count, out_valid, issue_tag, proto_err, issue_ready} !== {3'd0, 1'b0, 2'd0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL kill_state: got cnt=%0d ov=%b tag=%0d perr=%b rdy=%b required 0 0 0 0 1",
                  count, out_valid, issue_tag, proto_err, issue_ready);
      end
      set_fu(0, 2'd1, 24'h111111, 10'h011, 6'b000001, 1'b0);
      fu_tick();
      checks++;
      if ({proto_err, out_valid} !== {1'b1, 1'b0}) begin
         errors++;
         $display("FAIL kill_stale: got perr=%b ov=%b required 1 0", proto_err, out_valid);
      end
   endtask

   task automatic test_dup_and_done();
      do_kill();
      do_issue(3'd2, 2'd1);
      set_fu(0, 2'd0, 24'hAAAAAA, 10'h0AA, 6'b100100, 1'b1);
      set_fu(3, 2'd0, 24'h555555, 10'h155, 6'b011011, 1'b0);
      fu_tick();
      checks++;
      if (proto_err !== 1'b1) begin errors++; $display("FAIL dup_perr: got %b required 1", proto_err); end
      sb_check_head("dup");
      retire_one();
      do_kill();
      do_issue(3'd3, 2'd2);
      set_fu(2, 2'd0, 24'h0F0F0F, 10'h2F0, 6'b000110, 1'b1);
      fu_tick();
      checks++;
      if (proto_err !== 1'b0) begin errors++; $display("FAIL done_first: got perr=%b required 0", proto_err); end
      set_fu(1, 2'd0, 24'hF0F0F0, 10'h00F, 6'b111000, 1'b0);
      fu_tick();
      checks++;
      if (proto_err !== 1'b1) begin errors++; $display("FAIL done_again: got perr=%b required 1", proto_err); end
      sb_check_head("done_keep");
      retire_one();
      checks++;
      if (count !== 3'd0) begin errors++; $display("FAIL done_cnt: got %0d required 0", count); end
   endtask

   initial begin
      test_reset();
      test_in_order();
      test_out_of_order();
      test_full_wrap();
      test_backpressure();
      test_simultaneous();
      test_errors_kill();
      test_dup_and_done();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/airi5c_float_result_sequencer.md
Name: airi5c_float_result_sequencer

Overview:
- Parametrised in-order completion sequencer placed between the FPU arithmetic units (adder, multiplier, divider, sqrt, future units) and post-processing.
- Allows up to DEPTH operations in flight across N_UNITS units, each with its own latched rounding mode.
- Accepts out-of-order completions by tag and presents results to post-processing strictly in issue order, using a valid/ready handshake.
- Replaces the single-op priority mux and single rm register.

Parameters:
N_UNITS, 4, number of functional units with completion ports
TAG_W, 2, tag width; DEPTH = 2**TAG_W entries
MAN_W, 24, mantissa width per result
EXP_W, 10, exponent width per result

Ports:
clk  in  1  clock
n_reset  in  1  asynchronous active-low reset
kill  in  1  synchronous flush of all entries
issue_valid  in  1  new op dispatched to a unit
issue_ready  out  1  entry free, issue accepted
issue_unit  in  max(1,$clog2(N_UNITS))  destination unit index (stored for debug/out_unit)
issue_rm  in  3  rounding mode for this op
issue_tag  out  TAG_W  tag allocated to the op being issued (tail pointer)
fu_valid  in  N_UNITS  per-unit completion strobe
fu_tag  in  N_UNITS*TAG_W  per-unit completion tag, unit i at [i*TAG_W +: TAG_W]
fu_man  in  N_UNITS*MAN_W  per-unit mantissa
fu_exp  in  N_UNITS*EXP_W  per-unit exponent
fu_sgn, fu_round, fu_sticky, fu_iv, fu_dz, fu_final  in  N_UNITS each  per-unit sign/round/sticky/IV/DZ/final_res
out_valid  out  1  head entry complete
out_ready  in  1  post-processing accepts
out_man  out  MAN_W  head result fields
out_exp  out  EXP_W  head result fields
out_sgn, out_round, out_sticky, out_iv, out_dz, out_final  out  1 each  head result fields
out_rm  out  3  rounding mode latched at issue
out_unit  out  max(1,$clog2(N_UNITS))  unit latched at issue
out_tag  out  TAG_W  head tag
count  out  TAG_W+1  entries allocated
proto_err  out  1  sticky protocol-error flag

Behaviour:
Reset (n_reset low, asynchronous):
- head=tail=count=0; all entries invalid/not done.
- Outputs: issue_ready=1, issue_tag=0, out_valid=0, all out_* zero, proto_err=0.

Entry state:
- Each slot holds allocated, done, rm, unit, and the result fields.
- Slot states: FREE -> PENDING (on issue) -> DONE (on completion) -> FREE (on retire).

Issue:
- issue_ready = (count < DEPTH); there is no same-cycle pop bypass.
- On issue_valid && issue_ready: slot[tail] becomes PENDING with rm/unit captured, and tail increments mod DEPTH (wraps).
- issue_tag always equals tail.

Completion:
- For each i with fu_valid[i]: if slot[fu_tag_i] is PENDING, capture the fields and set DONE at the next edge.
- If the slot is FREE or already DONE: drop the completion and set proto_err.
- Two units completing the same tag in one cycle also sets proto_err; the lowest index wins.
- Completions to distinct tags in the same cycle are all captured.

Retire:
- out_valid = slot[head] DONE; out_* are driven from slot[head] when out_valid, zero otherwise.
- On out_valid && out_ready: slot[head] becomes FREE and head increments mod DEPTH.
- Latency: a completion at edge N is visible on out_* after edge N if its slot is the head (one cycle, registered storage).
- While out_ready=0, out_* stay stable.

Count:
- count += issue, -= retire; simultaneous issue and retire leave it unchanged.
- A full queue with a retire that cycle still deasserts issue_ready; the freed slot is available next cycle.

Kill:
- Takes priority over issue, completion and retire in the same cycle.
- Everything returns to reset values except proto_err, which kill also clears.
- Completions arriving after kill for flushed tags set proto_err.

Sizes:
- DEPTH is a power of two; pointers are TAG_W bits with natural wrap.
- count is TAG_W+1 bits, so it can represent DEPTH.

Test Plan:
1. In-order: issue rm=1 (tag0), rm=3 (tag1); unit0 completes tag0 man=24'h800000 exp=10'h07F, then unit2 completes tag1 -> out_tag 0 out_rm=1 man=24'h800000 exp=10'h07F, then out_tag 1 out_rm=3; count 2->1->0.
2. Out-of-order: issue tags 0,1; unit1 completes tag1 first -> out_valid stays 0; tag0 completes -> tag0 retires, then tag1 on the following cycle with out_ready=1.
3. Full/wrap: DEPTH=4; issue 4 ops -> count=4, issue_ready=0, 5th issue ignored; retire one -> issue_ready=1 next cycle and issue_tag=0 (wrapped).
4. Backpressure: head DONE with out_ready=0 for 5 cycles -> out_valid=1 and out_* unchanged, count unchanged; out_ready=1 -> single retire.
5. Simultaneous: units 0,1,2,3 complete tags 0,1,2,3 in one cycle -> 4 consecutive retires in order with out_ready=1; no proto_err.
6. Errors/kill: completion to a FREE tag -> proto_err=1 and nothing captured; kill with 3 pending -> count=0, out_valid=0, issue_tag=0, proto_err=0 next cycle.
